// File: rtl/sdram_burst_arbiter_if.sv
// Burst-command bus between the display/SPI requesters, the arbiter and the SDRAM
// controller command port. The slave modport is the arbiter's view.
interface sdram_burst_arbiter_if #(
  parameter int ADDR_W = 23
) ();
  logic              iRd_Req;
  logic [ADDR_W-1:0] iRd_Base;
  logic              iNew_Frame;
  logic              iWr_Req;
  logic [ADDR_W-1:0] iWr_Base;
  logic              iImg_Start;
  logic              oCmd_Valid;
  logic              iCmd_Ready;
  logic              oCmd_Wr;
  logic [ADDR_W-1:0] oCmd_Addr;
  logic              iBurst_Done;
  logic              oRd_Grant;
  logic              oWr_Grant;
  logic              oWr_Frame_Done;

  modport slave (
    input  iRd_Req, iRd_Base, iNew_Frame,
    input  iWr_Req, iWr_Base, iImg_Start,
    input  iCmd_Ready, iBurst_Done,
    output oCmd_Valid, oCmd_Wr, oCmd_Addr,
    output oRd_Grant, oWr_Grant, oWr_Frame_Done
  );

  modport master (
    output iRd_Req, iRd_Base, iNew_Frame,
    output iWr_Req, iWr_Base, iImg_Start,
    output iCmd_Ready, iBurst_Done,
    input  oCmd_Valid, oCmd_Wr, oCmd_Addr,
    input  oRd_Grant, oWr_Grant, oWr_Frame_Done
  );
endinterface

// File: rtl/sdram_burst_arbiter.sv
// Shares the SDRAM command port between display refill reads and SPI pixel writes:
// read priority with bounded write starvation, per-frame burst address generation.
module sdram_burst_arbiter #(
  parameter int ADDR_W        = 23,
  parameter int BURST_LEN     = 256,
  parameter int FRAME_WORDS   = 384000,
  parameter int RD_STREAK_MAX = 4
) (
  input logic                  iCLK,
  input logic                  iRSTN,
  sdram_burst_arbiter_if.slave bus
);

  localparam int SW = (RD_STREAK_MAX < 1) ? 1 : $clog2(RD_STREAK_MAX + 1);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] SPAN       = ADDR_W'(FRAME_WORDS);
  localparam logic [SW-1:0]     STREAK_MAX = SW'(RD_STREAK_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t            state, state_nx;
  logic              cur_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] rd_ptr, wr_ptr;
  logic              rd_pend, wr_pend;
  logic [SW-1:0]     streak;
  logic              frame_done;

  logic rd_reload, wr_reload, rd_ok, wr_ok, pick_wr, pick_any;
  logic accept, finish, rd_busy, wr_busy, rd_finish, wr_finish, wr_wrap;

  // Next burst address within the frame; wraps back to base after the last burst.
  function automatic logic [ADDR_W-1:0] advance(input logic [ADDR_W-1:0] ptr,
                                                input logic [ADDR_W-1:0] base);
    logic [ADDR_W-1:0] step_ptr, frame_end;
    step_ptr  = ptr + STEP;
    frame_end = base + SPAN;
    return (step_ptr == frame_end) ? base : step_ptr;
  endfunction

  // A requester whose pointer is about to be reloaded sits out arbitration until
  // the reload lands, so it never issues from a stale pointer.
  assign rd_reload = rd_pend | bus.iNew_Frame;
  assign wr_reload = wr_pend | bus.iImg_Start;
  assign rd_ok     = bus.iRd_Req & ~rd_reload;
  assign wr_ok     = bus.iWr_Req & ~wr_reload;
  assign pick_wr   = wr_ok & (~rd_ok | (streak == STREAK_MAX));
  assign pick_any  = rd_ok | wr_ok;

  assign accept    = (state == ISSUE) & bus.iCmd_Ready;
  assign finish    = (state == WAIT_DONE) & bus.iBurst_Done;
  assign rd_busy   = (state != IDLE) & ~cur_wr;
  assign wr_busy   = (state != IDLE) & cur_wr;
  assign rd_finish = finish & ~cur_wr;
  assign wr_finish = finish & cur_wr;
  assign wr_wrap   = ((wr_ptr + STEP) == (bus.iWr_Base + SPAN));

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx       = state;
    bus.oCmd_Valid = 1'b0;
    bus.oRd_Grant  = 1'b0;
    bus.oWr_Grant  = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_any) state_nx = ISSUE;
      end
      ISSUE: begin
        bus.oCmd_Valid = 1'b1;
        if (bus.iCmd_Ready) state_nx = WAIT_DONE;
      end
      WAIT_DONE: begin
        bus.oRd_Grant = ~cur_wr;
        bus.oWr_Grant = cur_wr;
        if (bus.iBurst_Done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.oCmd_Wr        = cur_wr;
  assign bus.oCmd_Addr      = cmd_addr;
  assign bus.oWr_Frame_Done = frame_done;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Winner and its address are latched at decision time and held through ISSUE.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      cur_wr   <= 1'b0;
      cmd_addr <= '0;
    end else if (state == IDLE && pick_any) begin
      cur_wr   <= pick_wr;
      cmd_addr <= pick_wr ? wr_ptr : rd_ptr;
    end
  end

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      streak <= '0;
    end else if (accept && cur_wr) begin
      streak <= '0;
    end else if (accept && bus.iWr_Req) begin
      if (streak != STREAK_MAX) streak <= streak + 1'b1;
    end else if (state == IDLE && !bus.iWr_Req) begin
      streak <= '0;
    end
  end

  // Reload lands immediately when idle; in flight it replaces that burst's increment.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      rd_ptr  <= '0;
      rd_pend <= 1'b0;
    end else if (rd_reload && (!rd_busy || rd_finish)) begin
      rd_ptr  <= bus.iRd_Base;
      rd_pend <= 1'b0;
    end else begin
      if (bus.iNew_Frame) rd_pend <= 1'b1;
      if (rd_finish)      rd_ptr  <= advance(rd_ptr, bus.iRd_Base);
    end
  end

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      wr_ptr  <= '0;
      wr_pend <= 1'b0;
    end else if (wr_reload && (!wr_busy || wr_finish)) begin
      wr_ptr  <= bus.iWr_Base;
      wr_pend <= 1'b0;
    end else begin
      if (bus.iImg_Start) wr_pend <= 1'b1;
      if (wr_finish)      wr_ptr  <= advance(wr_ptr, bus.iWr_Base);
    end
  end

  // Frame-done follows the wrap condition even when a reload overrides the wrap.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= wr_finish & wr_wrap;
    end
  end

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Bench for sdram_burst_arbiter: directed scenarios plus randomized request phases,
// checked against a burst-index model of each requester's frame walk.
module tb_sdram_burst_arbiter;

  localparam int AW  = 23;
  localparam int BL  = 8;
  localparam int FW  = 32;
  localparam int RSM = 2;
  localparam int NB  = FW / BL;

  logic clk, rst_n;
  sdram_burst_arbiter_if #(.ADDR_W(AW)) bus ();

  sdram_burst_arbiter #(
    .ADDR_W(AW), .BURST_LEN(BL), .FRAME_WORDS(FW), .RD_STREAK_MAX(RSM)
  ) dut (
    .iCLK (clk),
    .iRSTN(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic          rg;
    logic          wg;
    logic          gafter;
    logic          fd;
  } entry_t;

  entry_t        blog[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_acc    = 0;
  int            fd_cnt   = 0;
  int            ready_mode = 0;
  logic [AW-1:0] m_base[2];
  int            m_k[2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SDRAM controller stand-in: ready per ready_mode, done 4 cycles after accept.
  initial begin
    entry_t e;
    bus.iCmd_Ready  = 1'b1;
    bus.iBurst_Done = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       bus.iCmd_Ready = 1'b1;
        1:       bus.iCmd_Ready = 1'($urandom_range(0, 1));
        default: bus.iCmd_Ready = 1'b0;
      endcase
      #1;
      if (rst_n && bus.oCmd_Valid && bus.iCmd_Ready) begin
        e.wr   = bus.oCmd_Wr;
        e.addr = bus.oCmd_Addr;
        @(posedge clk);
        n_acc++;
        @(negedge clk);
        e.rg = bus.oRd_Grant;
        e.wg = bus.oWr_Grant;
        repeat (3) @(posedge clk);
        @(negedge clk);
        if (rst_n) begin
          bus.iBurst_Done = 1'b1;
          @(negedge clk);
          bus.iBurst_Done = 1'b0;
          e.gafter = bus.oRd_Grant | bus.oWr_Grant;
          e.fd     = bus.oWr_Frame_Done;
          blog.push_back(e);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.oWr_Frame_Done) fd_cnt++;
    end
  end

  task automatic m_reload(input int w, input logic [AW-1:0] base);
    m_base[w] = base;
    m_k[w]    = 0;
  endtask

  task automatic expect_burst(input logic w);
    entry_t        e;
    logic [AW-1:0] a;
    logic          wrap;
    int            wi;
    wi = w ? 1 : 0;
    check("log_entry", 32'(blog.size() > 0), 1);
    if (blog.size() == 0) return;
    e    = blog.pop_front();
    a    = m_base[wi] + AW'(m_k[wi] * BL);
    wrap = (m_k[wi] == NB - 1);
    m_k[wi] = wrap ? 0 : m_k[wi] + 1;
    check("cmd_wr", e.wr, w);
    check("cmd_addr", e.addr, a);
    check("rd_grant", e.rg, !w);
    check("wr_grant", e.wg, w);
    check("grant_drop", e.gafter, 0);
    check("frame_done", e.fd, w & wrap);
  endtask

  task automatic wait_acc(input int target);
    for (int i = 0; i < 3000 && n_acc < target; i++) @(negedge clk);
    check("accept_timeout", 32'(n_acc >= target), 1);
  endtask

  task automatic wait_log(input int n);
    for (int i = 0; i < 3000 && blog.size() < n; i++) @(negedge clk);
    check("done_timeout", 32'(blog.size() >= n), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic set_reqs(input logic rd, input logic wr);
    bus.iRd_Req = rd;
    bus.iWr_Req = wr;
  endtask

  task automatic pulse_reload(input logic rd, input logic wr);
    bus.iNew_Frame = rd;
    bus.iImg_Start = wr;
    @(negedge clk);
    bus.iNew_Frame = 1'b0;
    bus.iImg_Start = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, bus.oCmd_Valid, 0);
    check({tag, "_wr"}, bus.oCmd_Wr, 0);
    check({tag, "_addr"}, bus.oCmd_Addr, 0);
    check({tag, "_rgrant"}, bus.oRd_Grant, 0);
    check({tag, "_wgrant"}, bus.oWr_Grant, 0);
    check({tag, "_fdone"}, bus.oWr_Frame_Done, 0);
  endtask

  initial begin
    int start, mode, n;
    rst_n          = 1'b0;
    bus.iRd_Req    = 1'b0;
    bus.iWr_Req    = 1'b0;
    bus.iNew_Frame = 1'b0;
    bus.iImg_Start = 1'b0;
    bus.iRd_Base   = AW'('h100);
    bus.iWr_Base   = AW'('h400);
    #2;
    check_idle_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Read only, reload issued together with the request: valid two cycles later.
    bus.iNew_Frame = 1'b1;
    bus.iRd_Req    = 1'b1;
    m_reload(0, AW'('h100));
    @(negedge clk);
    bus.iNew_Frame = 1'b0;
    check("rd_latency_c1", bus.oCmd_Valid, 0);
    @(negedge clk);
    check("rd_latency_c2", bus.oCmd_Valid, 1);
    start = n_acc;
    wait_acc(start + 5);
    set_reqs(0, 0);
    wait_log(5);
    for (int i = 0; i < 5; i++) expect_burst(1'b0);

    // Both requests held: R,R,W,R,R,W.
    pulse_reload(1, 1);
    m_reload(0, AW'('h100));
    m_reload(1, AW'('h400));
    set_reqs(1, 1);
    start = n_acc;
    wait_acc(start + 6);
    set_reqs(0, 0);
    wait_log(6);
    for (int i = 0; i < 6; i++) expect_burst((i % (RSM + 1)) == RSM);

    // Full write frame: frame-done once on the 0x418 burst, then back to 0x400.
    pulse_reload(0, 1);
    m_reload(1, AW'('h400));
    fd_cnt = 0;
    set_reqs(0, 1);
    start = n_acc;
    wait_acc(start + 5);
    set_reqs(0, 0);
    wait_log(5);
    check("frame_done_count", fd_cnt, 1);
    for (int i = 0; i < 5; i++) expect_burst(1'b1);

    // Reload while the 0x108 read is in flight: next read restarts at 0x100.
    pulse_reload(1, 0);
    m_reload(0, AW'('h100));
    set_reqs(1, 0);
    start = n_acc;
    wait_acc(start + 2);
    check("reload_in_wait", bus.oRd_Grant, 1);
    bus.iNew_Frame = 1'b1;
    @(negedge clk);
    bus.iNew_Frame = 1'b0;
    wait_acc(start + 3);
    set_reqs(0, 0);
    wait_log(3);
    expect_burst(1'b0);
    expect_burst(1'b0);
    m_reload(0, AW'('h100));
    expect_burst(1'b0);

    // Backpressure: command held stable while ready is low and the request drops.
    ready_mode = 2;
    set_reqs(1, 0);
    for (int i = 0; i < 20 && !bus.oCmd_Valid; i++) @(negedge clk);
    check("bp_valid_seen", bus.oCmd_Valid, 1);
    set_reqs(0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", bus.oCmd_Valid, 1);
      check("bp_addr", bus.oCmd_Addr, AW'('h108));
      check("bp_wr", bus.oCmd_Wr, 0);
    end
    ready_mode = 0;
    wait_log(1);
    expect_burst(1'b0);

    // Asynchronous reset in the middle of WAIT_DONE.
    set_reqs(1, 0);
    start = n_acc;
    wait_acc(start + 1);
    check("rst_in_wait", bus.oRd_Grant, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    repeat (6) @(negedge clk);
    rst_n = 1'b1;
    blog.delete();
    start = n_acc;
    wait_acc(start + 1);
    set_reqs(0, 0);
    wait_log(1);
    m_reload(0, AW'('h000));
    expect_burst(1'b0);
    pulse_reload(1, 0);
    m_reload(0, AW'('h100));
    set_reqs(1, 0);
    start = n_acc;
    wait_acc(start + 1);
    set_reqs(0, 0);
    wait_log(1);
    expect_burst(1'b0);

    // Randomized phases: random bases, request mix and ready backpressure.
    ready_mode = 1;
    for (int ph = 0; ph < 8; ph++) begin
      mode = int'($urandom_range(0, 2));
      n    = int'($urandom_range(3, 7));
      if (ph == 0 || $urandom_range(0, 1) == 1) begin
        bus.iRd_Base = AW'($urandom_range(0, (1 << AW) - 1));
        bus.iWr_Base = AW'($urandom_range(0, (1 << AW) - 1));
        pulse_reload(1, 1);
        m_reload(0, bus.iRd_Base);
        m_reload(1, bus.iWr_Base);
      end
      set_reqs(mode != 1, mode != 0);
      start = n_acc;
      wait_acc(start + n);
      set_reqs(0, 0);
      wait_log(n);
      for (int i = 0; i < n; i++) begin
        if (mode == 0)      expect_burst(1'b0);
        else if (mode == 1) expect_burst(1'b1);
        else                expect_burst((i % (RSM + 1)) == RSM);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
